tanh_batch_driver: RTL and testbench

Upstream sequencer for the tanh unit. It holds a small buffer of input samples and feeds them to tanh one at a time through the Start/Ready handshake. It captures each rBus result into a result buffer, then signals completion to the host side. A watchdog aborts the batch if tanh stops responding.

---
 rtl/tanh_batch_driver.sv | 177 +++++++++++++++++
 tb/tb_tanh_batch_driver.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/tanh_batch_driver.sv
// ---------------------------------------------------------------------------
// tanh_batch_driver : buffers input samples, feeds them to the tanh unit one
// at a time via Start/Ready, stores results, aborts on a per-sample timeout.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tanh_batch_driver #(
  parameter int W       = 16,
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          go,
  input  logic [AW:0]   len,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] err_idx,
  output logic [W-1:0]  xBus,
  output logic          Start,
  input  logic          Ready,
  input  logic [W-1:0]  rBus
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_FIN       = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic          start_q, start_d;
  logic [W-1:0]  xbus_q, xbus_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [AW-1:0] err_idx_q, err_idx_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [AW:0]   n_q, n_d;
  logic          out_we;

  logic [W-1:0]  inbuf_q  [DEPTH];
  logic [W-1:0]  outbuf_q [DEPTH];

  logic [AW:0]   n_clamp;
  logic          last_sample;
  logic          timed_out;

  assign n_clamp     = (len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : len;
  assign last_sample = ({1'b0, idx_q} == (n_q - (AW+1)'(1)));
  assign timed_out   = (timer_q == TW'(TIMEOUT));

  always_comb begin
    state_d   = state_q;
    start_d   = 1'b0;
    xbus_d    = xbus_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    err_idx_d = err_idx_q;
    idx_d     = idx_q;
    timer_d   = timer_q;
    n_d       = n_q;
    out_we    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (go) begin
          n_d     = n_clamp;
          idx_d   = '0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = (n_clamp == '0) ? S_FIN : S_ISSUE;
        end
      end
      S_ISSUE: begin
        xbus_d  = inbuf_q[idx_q];
        start_d = 1'b1;
        timer_d = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        timer_d = timer_q + TW'(1);
        // A completed handshake takes priority over a timeout on the same cycle.
        if (!Ready) begin
          state_d = S_WAIT_DONE;
        end else if (timed_out) begin
          err_d     = 1'b1;
          err_idx_d = idx_q;
          state_d   = S_FIN;
        end
      end
      S_WAIT_DONE: begin
        timer_d = timer_q + TW'(1);
        if (Ready) begin
          out_we = 1'b1;
          if (last_sample) begin
            state_d = S_FIN;
          end else begin
            idx_d   = idx_q + AW'(1);
            state_d = S_ISSUE;
          end
        end else if (timed_out) begin
          err_d     = 1'b1;
          err_idx_d = idx_q;
          state_d   = S_FIN;
        end
      end
      S_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      start_q   <= 1'b0;
      xbus_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      err_idx_q <= '0;
      idx_q     <= '0;
      timer_q   <= '0;
      n_q       <= '0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      xbus_q    <= xbus_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      err_idx_q <= err_idx_d;
      idx_q     <= idx_d;
      timer_q   <= timer_d;
      n_q       <= n_d;
    end
  end

  // Buffers are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en && !busy_q) begin
      inbuf_q[wr_addr] <= wr_data;
    end
    if (out_we) begin
      outbuf_q[idx_q] <= rBus;
    end
  end

  assign rd_data = outbuf_q[rd_addr];
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign err_idx = err_idx_q;
  assign xBus    = xbus_q;
  assign Start   = start_q;

endmodule

`default_nettype wire

// File: tb/tb_tanh_batch_driver.sv
// Directed bench for tanh_batch_driver with a behavioural tanh responder.
`default_nettype none

module tb_tanh_batch_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        go = 1'b0;
  logic [4:0]  len = '0;
  logic [3:0]  rd_addr = '0;
  logic [15:0] rd_data;
  logic        busy, done, err;
  logic [3:0]  err_idx;
  logic [15:0] xBus;
  logic        Start;
  logic        Ready = 1'b1;
  logic [15:0] rBus = '0;

  int vectors = 0;
  int miscompares = 0;

  tanh_batch_driver dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .go(go), .len(len), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy),
    .done(done), .err(err), .err_idx(err_idx), .xBus(xBus), .Start(Start),
    .Ready(Ready), .rBus(rBus)
  );

  always #5 clk = ~clk;

  // tanh model: drops Ready the cycle after Start, returns 6 cycles later.
  int   cnt = 0;
  int   model_starts = 0;
  int   hang_at = -1;
  logic hanging = 1'b0;
  always @(posedge clk) begin
    if (rst) begin
      Ready   <= 1'b1;
      cnt     <= 0;
      hanging <= 1'b0;
    end else if (hanging) begin
      if (hang_at < 0) begin
        hanging <= 1'b0;
        Ready   <= 1'b1;
      end
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) begin
        Ready <= 1'b1;
        rBus  <= xBus ^ 16'hA5A5;
      end
    end else if (Start) begin
      model_starts <= model_starts + 1;
      Ready        <= 1'b0;
      if (model_starts == hang_at) hanging <= 1'b1;
      else cnt <= 6;
    end
  end

  int   start_pulses = 0;
  int   start_hi = 0;
  logic start_prev = 1'b0;
  always @(posedge clk) begin
    if (Start && !start_prev) start_pulses <= start_pulses + 1;
    if (Start) start_hi <= start_hi + 1;
    start_prev <= Start;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic pulse_go(input logic [4:0] l);
    go = 1'b1; len = l;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int cyc);
    cyc = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (done) begin
        cyc = i;
        break;
      end
    end
    chk("done_within_bound", 32'(cyc > 0), 32'd1);
  endtask

  task automatic rd(input logic [3:0] a, input logic [15:0] exp, input string tag);
    rd_addr = a;
    #1;
    chk(tag, 32'(rd_data), 32'(exp));
  endtask

  initial begin
    int cyc;
    int s0, h0;
    int k;
    logic seen;

    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset and idle
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_outputs", {8'd0, Start, busy, done, err, err_idx, xBus}, 32'd0);
    end
    chk("idle_no_start", 32'(start_pulses), 32'd0);

    // Single sample
    wr(4'd0, 16'h1234);
    s0 = start_pulses; h0 = start_hi;
    pulse_go(5'd1);
    chk("single_busy", 32'(busy), 32'd1);
    wait_done(100, cyc);
    chk("single_pulses", 32'(start_pulses - s0), 32'd1);
    chk("single_start_width", 32'(start_hi - h0), 32'd1);
    chk("single_xbus", 32'(xBus), 32'h1234);
    rd(4'd0, 16'hB791, "single_result");
    chk("single_err", 32'(err), 32'd0);
    @(negedge clk);
    chk("single_done_1cyc", {busy, done}, 32'd0);

    // Full batch, len clamped
    for (int i = 0; i < 16; i++) wr(4'(i), 16'(i * 16'h0101));
    s0 = start_pulses; h0 = start_hi;
    pulse_go(5'd20);
    wait_done(1000, cyc);
    chk("full_pulses", 32'(start_pulses - s0), 32'd16);
    chk("full_start_width", 32'(start_hi - h0), 32'd16);
    chk("full_err", 32'(err), 32'd0);
    for (int i = 0; i < 16; i++) rd(4'(i), 16'(i * 16'h0101) ^ 16'hA5A5, "full_result");
    @(negedge clk);

    // len = 0
    s0 = start_pulses;
    pulse_go(5'd0);
    chk("len0_no_early_done", {busy, done}, 32'h2);
    wait_done(10, cyc);
    chk("len0_latency", 32'(cyc + 1), 32'd2);
    chk("len0_no_start", 32'(start_pulses - s0), 32'd0);
    rd(4'd0, 16'hA5A5, "len0_outbuf_kept");
    @(negedge clk);

    // Timeout at sample 2
    wr(4'd0, 16'h1000); wr(4'd1, 16'h2000); wr(4'd2, 16'h3000); wr(4'd3, 16'h4000);
    hang_at = model_starts + 2;
    pulse_go(5'd4);
    wait_done(2000, cyc);
    chk("to_err", 32'(err), 32'd1);
    chk("to_err_idx", 32'(err_idx), 32'd2);
    rd(4'd0, 16'hB5A5, "to_out0");
    rd(4'd1, 16'h85A5, "to_out1");
    rd(4'd2, 16'hA7A7, "to_out2_kept");
    rd(4'd3, 16'hA6A6, "to_out3_kept");
    hang_at = -1;
    @(negedge clk);
    chk("to_busy_low", 32'(busy), 32'd0);
    @(negedge clk);
    pulse_go(5'd0);
    chk("go_clears_err", 32'(err), 32'd0);
    wait_done(10, cyc);
    @(negedge clk);

    // Reset in WAIT_DONE of sample 1
    pulse_go(5'd4);
    k = 0;
    for (int i = 0; i < 200 && k < 2; i++) begin
      @(negedge clk);
      if (Start) k++;
    end
    chk("mid_second_start", 32'(k), 32'd2);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_outputs", {Start, busy, done}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || Start || busy) seen = 1'b1;
    end
    chk("mid_rst_quiet", 32'(seen), 32'd0);

    // go and wr_en while busy are ignored
    s0 = start_pulses;
    pulse_go(5'd2);
    go = 1'b1; len = 5'd1; wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'hFFFF;
    repeat (3) @(negedge clk);
    go = 1'b0; wr_en = 1'b0;
    wait_done(200, cyc);
    chk("busy_go_ignored", 32'(start_pulses - s0), 32'd2);
    rd(4'd0, 16'hB5A5, "busy_wr_ignored0");
    rd(4'd1, 16'h85A5, "busy_wr_ignored1");
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || Start) seen = 1'b1;
    end
    chk("no_extra_batch", 32'(seen), 32'd0);

    // wr_en and go in the same IDLE cycle
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'h5A5A;
    pulse_go(5'd1);
    wr_en = 1'b0;
    wait_done(100, cyc);
    rd(4'd0, 16'hFFFF, "same_cycle_wr_go");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
